key_uart_tx: RTL and testbench
==============================

KEY_UART_TX -- requirements
Module: key_uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000; system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200; serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 8; keystroke queue entries, power of two, at least 2.
REQ-004 clk  input  1  system clock; single clock domain, rising edge.
REQ-005 nrst  input  1  asynchronous active-low reset.
REQ-006 keystroke  input  8  ASCII code, or arrow code 0xE0 up / 0xE1 down / 0xE2 left / 0xE3 right; valid only when done=1.
REQ-007 done  input  1  one-cycle valid strobe for keystroke.
REQ-008 tx  output  1  UART serial out, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while the serializer is not IDLE or the FIFO is non-empty.
REQ-010 overflow  output  1  sticky flag; set when a keystroke is dropped.

Function
REQ-011 done=1 with the FIFO not full SHALL write keystroke into the FIFO at that clock edge.
REQ-012 Full is evaluated before the edge: a push while full SHALL drop the byte and set overflow, even if a pop occurs in the same cycle.
REQ-013 A pop and an accepted push in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-014 Read and write pointers SHALL wrap modulo FIFO_DEPTH. Full and empty SHALL be distinguished by a count or an extra pointer bit.
REQ-015 BIT_CLKS = CLK_FREQ/BAUD, using integer truncation (868 at the defaults). Every UART bit SHALL last exactly BIT_CLKS cycles.
REQ-016 Serializer FSM states: IDLE, START, DATA, STOP.
- IDLE -> START when the FIFO is non-empty or an escape byte is pending.
- START -> DATA after 1 bit.
- DATA -> STOP after 8 bits.
- STOP -> IDLE after 1 bit.
REQ-017 tx SHALL be 1 in IDLE and STOP, 0 in START, and data[bit_idx] in DATA, with bit 0 first.
REQ-018 Each FIFO pop SHALL occur on the IDLE->START transition. The popped byte SHALL be held in a transmit register for the whole frame.
REQ-019 A popped byte in the range 0xE0-0xE3 SHALL be sent as the 3-frame ANSI sequence 0x1B, 0x5B, X, where X is:
- 0x41 for 0xE0 (up)
- 0x42 for 0xE1 (down)
- 0x44 for 0xE2 (left)
- 0x43 for 0xE3 (right)
REQ-020 Frames 2 and 3 of an escape sequence SHALL be sourced from an internal escape counter, not the FIFO. No FIFO pop SHALL occur until frame 3 has completed.
REQ-021 All other byte values, including 0x08 and 0x20, SHALL be transmitted unchanged as one frame.
REQ-022 Back-to-back frames SHALL have exactly 1 IDLE cycle between the end of STOP and the next START.
REQ-023 Latency: done high at edge k with the FIFO empty and the FSM idle SHALL give tx=0 after edge k+2.
REQ-024 busy SHALL go high the cycle after an accepted push. It SHALL fall only in IDLE with the FIFO empty and no escape byte pending.

Reset
REQ-025 nrst=0 SHALL immediately force the following, regardless of clk:
- tx=1, busy=0, overflow=0
- FSM=IDLE
- FIFO pointers and count=0
- bit counter, baud counter and escape counter=0
REQ-026 Reset during a frame SHALL abort it. tx SHALL return high with no partial stop bit required.
REQ-027 overflow SHALL clear only on reset.

Structure
REQ-028 FSM state encodings, arrow codes 0xE0-0xE3 and ANSI constants 0x1B, 0x5B, 0x41-0x44 SHALL live in a shared package, reused by the PS/2 decoder side.
REQ-029 The FIFO SHALL be a sub-module named sync_fifo, parameterised by width and depth, with push/pop/full/empty ports. The serializer and escape logic SHALL stay in key_uart_tx.

Verification
REQ-030 Send keystroke=0x61 ('a'). Required: after 2 cycles tx=0 for 868 cycles, then data bits 1,0,0,0,0,1,1,0 at 868 cycles each, then tx=1. busy falls after STOP plus 1 cycle.
REQ-031 Send keystroke=0xE2. Required: three frames carrying 0x1B, 0x5B, 0x44, with 1 idle cycle between them.
REQ-032 Send 9 keystrokes 0x30-0x38 on consecutive cycles with FIFO_DEPTH=8. Required:
- 0x30 is popped immediately, so 0x31-0x38 all fit and overflow stays 0.
- 9 frames are sent in order.
- An additional 10th push sent while full sets overflow=1 and is never transmitted.
REQ-033 Push while full, coinciding with a pop on the IDLE->START edge. Required: the pushed byte is dropped, overflow=1, and the count decrements by 1.
REQ-034 Assert nrst=0 mid-DATA of 0x55. Required: tx=1, busy=0, FIFO empty, asynchronously. Next push 0x41 then transmits a clean full frame.
REQ-035 Send 0xE0 followed immediately by 0x08. Required: frames 0x1B, 0x5B, 0x41, 0x08 in that order.

Source files
------------

// File: rtl/key_uart_tx_pkg.sv
// Shared constants for the keyboard path: serializer state encoding, the
// arrow-key codes produced by the PS/2 decoder, and the ANSI bytes that the
// UART side expands them into.
package key_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Arrow codes emitted by the PS/2 decoder
  localparam logic [7:0] KEY_UP    = 8'hE0;
  localparam logic [7:0] KEY_DOWN  = 8'hE1;
  localparam logic [7:0] KEY_LEFT  = 8'hE2;
  localparam logic [7:0] KEY_RIGHT = 8'hE3;

  // ANSI cursor sequence: ESC '[' <final>
  localparam logic [7:0] ANSI_ESC   = 8'h1B;
  localparam logic [7:0] ANSI_CSI   = 8'h5B;
  localparam logic [7:0] ANSI_UP    = 8'h41;
  localparam logic [7:0] ANSI_DOWN  = 8'h42;
  localparam logic [7:0] ANSI_RIGHT = 8'h43;
  localparam logic [7:0] ANSI_LEFT  = 8'h44;

  // Arrow codes occupy 0xE0-0xE3, so only the low two bits differ.
  function automatic logic is_arrow(input logic [7:0] code);
    return code[7:2] == KEY_UP[7:2];
  endfunction

  // Note the ANSI order is up/down/right/left, not the key-code order.
  function automatic logic [7:0] arrow_final(input logic [1:0] sel);
    case (sel)
      2'd0:    return ANSI_UP;
      2'd1:    return ANSI_DOWN;
      2'd2:    return ANSI_LEFT;
      default: return ANSI_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/key_uart_tx_sync_fifo.sv
// Single-clock FIFO, first-word fall-through (rdata_o shows the head entry).
// Ports:
//   clk_i, nrst_i      clock / async active-low reset
//   push_i, wdata_i    write strobe and data; ignored while full_o
//   pop_i, rdata_o     read strobe and head data; ignored while empty_o
//   full_o, empty_o    status, both derived from the entry count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  // Full/empty come from registered state, so a push into a full FIFO is
  // dropped even if the same edge pops an entry.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap for free.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/key_uart_tx.sv
// Keystroke-to-UART transmitter. Keystrokes are queued in a FIFO and sent
// 8N1, LSB first. Arrow codes 0xE0-0xE3 expand to ESC '[' <A|B|D|C>.
// Ports:
//   clk, nrst        clock / async active-low reset
//   keystroke, done  byte and its one-cycle valid strobe
//   tx               serial output, idle high
//   busy             serializer active, FIFO non-empty or escape bytes pending
//   overflow         sticky; a keystroke arrived while the FIFO was full
module key_uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] keystroke,
  input  logic       done,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);
  import key_uart_tx_pkg::*;

  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BIT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CLKS - 1);

  tx_state_e  state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] esc_q, esc_d;          // escape bytes still to send after ESC
  logic [7:0] esc_chr_q, esc_chr_d;  // final byte of the pending sequence
  logic [7:0] data_q, data_d;        // byte of the frame in flight
  logic       tx_q, tx_d, busy_q, busy_d, ovf_q;
  logic       fifo_full, fifo_empty, fifo_pop, bit_end;
  logic [7:0] fifo_rdata;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .nrst_i  (nrst),
    .push_i  (done),
    .wdata_i (keystroke),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_end  = (baud_q == BIT_LAST);
  // Pending escape bytes take priority; the FIFO is only read once they are out.
  assign fifo_pop = (state_q == ST_IDLE) && (esc_q == 2'd0) && !fifo_empty;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      esc_q     <= '0;
      esc_chr_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      esc_q     <= esc_d;
      esc_chr_q <= esc_chr_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_q | (done & fifo_full);
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    esc_d     = esc_q;
    esc_chr_d = esc_chr_q;
    data_d    = data_q;
    if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (esc_q != 2'd0) begin
          state_d = ST_START;
          esc_d   = esc_q - 2'd1;
          data_d  = (esc_q == 2'd2) ? ANSI_CSI : esc_chr_q;
        end else if (!fifo_empty) begin
          state_d = ST_START;
          if (is_arrow(fifo_rdata)) begin
            data_d    = ANSI_ESC;
            esc_d     = 2'd2;
            esc_chr_d = arrow_final(fifo_rdata[1:0]);
          end else begin
            data_d = fifo_rdata;
          end
        end
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = ST_STOP;
      end
      ST_STOP: if (bit_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // tx and busy are registered, so the line trails the state by one cycle;
  // this gives the two-edge done-to-start-bit latency and lets busy drop
  // exactly when the stop bit ends on the wire.
  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = data_q[bit_q];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE) || !fifo_empty || (esc_q != 2'd0);
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_uart_tx.sv
module tb_key_uart_tx;
  localparam int BIT_CLKS = 10;  // 1050 / 100, truncated

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic [7:0] keystroke = 8'h00;
  logic done = 1'b0;
  logic tx, busy, overflow;

  key_uart_tx #(.CLK_FREQ(1050), .BAUD(100), .FIFO_DEPTH(8)) dut (
    .clk(clk), .nrst(nrst), .keystroke(keystroke), .done(done),
    .tx(tx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Line monitor: decodes frames, checks every bit lasts BIT_CLKS cycles,
  // and records the idle run preceding each start bit.
  logic [7:0] rxq[$];
  int gapq[$];
  int m_err = 0, m_t = 0, m_idle = 0, m_bi = 0;
  logic m_act = 1'b0;
  logic [7:0] m_sh = 8'h00;

  always @(negedge clk) begin
    if (!nrst) begin
      m_act = 1'b0;
      m_idle = 0;
    end else begin
      if (!m_act && tx === 1'b0) begin
        m_act = 1'b1;
        m_t = 0;
        gapq.push_back(m_idle);
      end else if (!m_act) begin
        m_idle++;
      end
      if (m_act) begin
        m_t++;
        m_bi = (m_t - 1) / BIT_CLKS;
        if (m_bi == 0) begin
          if (tx !== 1'b0) m_err++;
        end else if (m_bi <= 8) begin
          if ((m_t - 1) % BIT_CLKS == 0) m_sh[m_bi-1] = tx;
          else if (tx !== m_sh[m_bi-1]) m_err++;
        end else begin
          if (tx !== 1'b1) m_err++;
          if (m_t == 10 * BIT_CLKS) begin
            rxq.push_back(m_sh);
            m_act = 1'b0;
            m_idle = 0;
          end
        end
      end
    end
  end

  logic [7:0] expq[$];

  task automatic clr();
    rxq.delete();
    gapq.delete();
    expq.delete();
  endtask

  task automatic push(input logic [7:0] b);
    keystroke = b;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (busy && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_timeout"}, busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_rx(input string nm);
    int bad = 0, gbad = 0;
    chk({nm, "_nframes"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i >= rxq.size() || rxq[i] !== expq[i]) bad++;
    chk({nm, "_bytes"}, bad, 0);
    for (int i = 1; i < gapq.size(); i++)
      if (gapq[i] != 1) gbad++;
    chk({nm, "_gaps"}, gbad, 0);
  endtask

  task automatic do_reset();
    #2 nrst = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [7:0]      key;
    logic [2:0]      n;
    logic [3:0][7:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] k, input int n,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    vec_t v;
    v.key = k; v.n = 3'(n);
    v.exp = '0;
    v.exp[0] = a; v.exp[1] = b; v.exp[2] = c;
    return v;
  endfunction

  vec_t vecs[9];
  logic [7:0] ch;

  initial begin
    vecs[0] = mk(8'h61, 1, 8'h61, 8'h00, 8'h00);
    vecs[1] = mk(8'hE0, 3, 8'h1B, 8'h5B, 8'h41);
    vecs[2] = mk(8'hE1, 3, 8'h1B, 8'h5B, 8'h42);
    vecs[3] = mk(8'hE2, 3, 8'h1B, 8'h5B, 8'h44);
    vecs[4] = mk(8'hE3, 3, 8'h1B, 8'h5B, 8'h43);
    vecs[5] = mk(8'h08, 1, 8'h08, 8'h00, 8'h00);
    vecs[6] = mk(8'h20, 1, 8'h20, 8'h00, 8'h00);
    vecs[7] = mk(8'hDF, 1, 8'hDF, 8'h00, 8'h00);
    vecs[8] = mk(8'hE4, 1, 8'hE4, 8'h00, 8'h00);

    // Reset asserted before any clock edge must act immediately.
    #1 nrst = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk); @(posedge clk);
    #2 nrst = 1'b1;
    @(posedge clk); #1;

    // Single 'a' frame, cycle-exact waveform and busy edges.
    clr();
    ch = 8'h61;
    push(ch);
    @(posedge clk); #1;
    chk("lat_k1_tx", tx, 1);
    chk("busy_rise", busy, 1);
    begin
      int werr = 0;
      logic eb;
      for (int m = 0; m < 10 * BIT_CLKS; m++) begin
        @(posedge clk); #1;
        if (m / BIT_CLKS == 0) eb = 1'b0;
        else if (m / BIT_CLKS == 9) eb = 1'b1;
        else eb = ch[m / BIT_CLKS - 1];
        if (m == 0) chk("lat_k2_tx", tx, 0);
        if (tx !== eb) werr++;
      end
      chk("a_wave", werr, 0);
    end
    chk("busy_in_stop", busy, 1);
    @(posedge clk); #1;
    chk("busy_fall", busy, 0);
    chk("idle_tx", tx, 1);
    expq.push_back(8'h61);
    chk_rx("a_frame");

    // Table: single keystrokes, including arrow codes and range edges.
    for (int i = 0; i < 9; i++) begin
      clr();
      for (int j = 0; j < int'(vecs[i].n); j++) expq.push_back(vecs[i].exp[j]);
      push(vecs[i].key);
      wait_idle($sformatf("vec%0d", i), 40 * BIT_CLKS);
      chk_rx($sformatf("vec%0d_%02h", i, vecs[i].key));
    end

    // Nine back-to-back keystrokes fit; the tenth is dropped.
    clr();
    for (int i = 0; i < 9; i++) begin
      push(8'h30 + 8'(i));
      expq.push_back(8'h30 + 8'(i));
    end
    chk("burst9_ovf", overflow, 0);
    push(8'h39);
    chk("burst10_ovf", overflow, 1);
    wait_idle("burst", 120 * BIT_CLKS);
    chk_rx("burst");
    chk("ovf_sticky", overflow, 1);

    // Push into a full FIFO on the same edge the FSM pops.
    do_reset();
    clr();
    for (int i = 0; i < 9; i++) begin
      push(8'h40 + 8'(i));
      expq.push_back(8'h40 + 8'(i));
    end
    repeat (10 * BIT_CLKS - 7) @(posedge clk);
    #1;
    chk("coinc_pre_ovf", overflow, 0);
    push(8'h5A);
    chk("coinc_ovf", overflow, 1);
    push(8'h77);
    expq.push_back(8'h77);
    wait_idle("coinc", 120 * BIT_CLKS);
    chk_rx("coinc");

    // Reset in the middle of a data bit of 0x55.
    do_reset();
    clr();
    push(8'h55);
    repeat (2 * BIT_CLKS + 5) @(posedge clk);
    #1;
    chk("mid_pre_tx", tx, 0);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge clk);
    #2 nrst = 1'b1;
    @(posedge clk); #1;
    clr();
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    chk("post_rst_quiet", rxq.size(), 0);
    chk("post_rst_busy", busy, 0);
    push(8'h41);
    expq.push_back(8'h41);
    wait_idle("post_rst", 20 * BIT_CLKS);
    chk_rx("post_rst");

    // Arrow followed immediately by backspace.
    clr();
    push(8'hE0);
    push(8'h08);
    expq.push_back(8'h1B); expq.push_back(8'h5B);
    expq.push_back(8'h41); expq.push_back(8'h08);
    wait_idle("esc_bs", 60 * BIT_CLKS);
    chk_rx("esc_bs");

    chk("frame_err", m_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
